// File: rtl/reg_seq_ctrl.sv
// Register-file sequencing controller: accepts one instruction at a time and walks
// it through DECODE, an optional memory phase and a single write-back cycle.
module reg_seq_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        InstrValid,
   input  logic [15:0] Instr,
   output logic        InstrReady,
   output logic [2:0]  SelA,
   output logic [2:0]  SelB,
   output logic [2:0]  SelWR,
   output logic        WE,
   output logic        Cen,
   output logic [1:0]  DataSel,
   output logic [7:0]  Imm,
   output logic [2:0]  AluOp,
   output logic        MemReq,
   output logic        MemWr,
   input  logic        MemAck,
   output logic        Busy,
   output logic        Illegal,
   output logic        Timeout
);

   typedef enum logic [1:0] {IDLE, DECODE, MEM, WB} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     nextState;
   logic [3:0] opQ;
   logic [7:0] waitCnt;
   logic       isAlu;
   logic       isMem;
   logic       isLd;
   logic       memExpired;

   assign isAlu      = (opQ != 4'd0) && !opQ[3];
   assign isMem      = (opQ == 4'd8) || (opQ == 4'd9);
   assign isLd       = (opQ == 4'd8);
   assign memExpired = (waitCnt == WAIT_LAST);

   // Gated by Rst so the handshake is refused while reset is asserted.
   assign InstrReady = (state == IDLE) && Rst;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (InstrValid) nextState = DECODE;
         DECODE: begin
            if (isAlu)      nextState = WB;
            else if (isMem) nextState = MEM;
            else            nextState = IDLE;
         end
         MEM: begin
            if (MemAck)          nextState = isLd ? WB : IDLE;
            else if (memExpired) nextState = IDLE;
         end
         WB:      nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state   <= IDLE;
         opQ     <= 4'd0;
         waitCnt <= 8'd0;
         SelA    <= 3'd0;
         SelB    <= 3'd0;
         SelWR   <= 3'd0;
         Imm     <= 8'd0;
         AluOp   <= 3'd0;
         WE      <= 1'b0;
         Cen     <= 1'b0;
         DataSel <= 2'd0;
         MemReq  <= 1'b0;
         MemWr   <= 1'b0;
         Busy    <= 1'b0;
         Illegal <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state <= nextState;

         // Fields are captured only at the handshake and held until the next one.
         if (state == IDLE && InstrValid) begin
            opQ   <= Instr[15:12];
            SelWR <= Instr[11:9];
            SelA  <= Instr[8:6];
            SelB  <= Instr[5:3];
            Imm   <= Instr[7:0];
            AluOp <= Instr[14:12];
         end

         Busy    <= (nextState != IDLE);
         Cen     <= (nextState != IDLE);
         WE      <= (nextState == WB);
         DataSel <= (nextState == WB) ? (isLd ? 2'd2 : ((opQ == 4'd7) ? 2'd1 : 2'd0)) : 2'd0;
         MemReq  <= (nextState == MEM);
         MemWr   <= (nextState == MEM) && (opQ == 4'd9);
         Illegal <= (state == DECODE) && (opQ >= 4'd10);
         // An acknowledge on the final wait cycle takes priority over the abort.
         Timeout <= (state == MEM) && !MemAck && memExpired;
         waitCnt <= (state == MEM) ? waitCnt + 8'd1 : 8'd0;
      end
   end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl: a per-instruction trace model predicts every
// cycle's outputs, and a negedge process compares the DUT against it.
`timescale 1ns/1ps
module tb_reg_seq_ctrl;

   localparam int TO = 15;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        InstrValid = 1'b0;
   logic [15:0] Instr = 16'h0000;
   logic        MemAck = 1'b0;
   logic        InstrReady, WE, Cen, MemReq, MemWr, Busy, Illegal, Timeout;
   logic [2:0]  SelA, SelB, SelWR, AluOp;
   logic [1:0]  DataSel;
   logic [7:0]  Imm;

   int errors = 0;
   int checks = 0;
   int memCnt;

   typedef struct packed {
      bit       busy;
      bit       we;
      bit [1:0] ds;
      bit [2:0] sa;
      bit [2:0] sb;
      bit [2:0] sw;
      bit [7:0] imm;
      bit [2:0] alu;
      bit       mreq;
      bit       mwr;
      bit       ill;
      bit       tmo;
   } rec_t;

   rec_t expQ[$];
   rec_t tr[$];

   reg_seq_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .Instr(Instr),
      .InstrReady(InstrReady), .SelA(SelA), .SelB(SelB), .SelWR(SelWR),
      .WE(WE), .Cen(Cen), .DataSel(DataSel), .Imm(Imm), .AluOp(AluOp),
      .MemReq(MemReq), .MemWr(MemWr), .MemAck(MemAck), .Busy(Busy),
      .Illegal(Illegal), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t mk(bit busy, bit we, bit [1:0] ds, bit mreq, bit mwr,
                               bit ill, bit tmo, logic [15:0] ins);
      rec_t r;
      r.busy = busy; r.we = we; r.ds = ds; r.mreq = mreq; r.mwr = mwr;
      r.ill = ill; r.tmo = tmo;
      r.sa = ins[8:6]; r.sb = ins[5:3]; r.sw = ins[11:9];
      r.imm = ins[7:0]; r.alu = ins[14:12];
      return r;
   endfunction

   // Cycle trace after the handshake edge; ack = MEM cycle carrying MemAck (0 = never).
   task automatic model(input logic [15:0] ins, input int ack);
      int  op;
      int  nMem;
      bit  acked;
      op = int'(ins[15:12]);
      tr.delete();
      tr.push_back(mk(1, 0, 2'd0, 0, 0, 0, 0, ins));
      if (op >= 1 && op <= 7) begin
         tr.push_back(mk(1, 1, (op == 7) ? 2'd1 : 2'd0, 0, 0, 0, 0, ins));
      end else if (op == 8 || op == 9) begin
         acked = (ack >= 1 && ack <= TO);
         nMem  = acked ? ack : TO;
         repeat (nMem) tr.push_back(mk(1, 0, 2'd0, 1, op == 9, 0, 0, ins));
         if (acked && op == 8) tr.push_back(mk(1, 1, 2'd2, 0, 0, 0, 0, ins));
         else if (!acked)      tr.push_back(mk(0, 0, 2'd0, 0, 0, 0, 1, ins));
      end else if (op >= 10) begin
         tr.push_back(mk(0, 0, 2'd0, 0, 0, 1, 0, ins));
      end
   endtask

   // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
   task automatic issue(input logic [15:0] ins, input int ack, input int nextIns,
                        input int rstAt, output int mc);
      int op;
      int nBusy;
      op = int'(ins[15:12]);
      mc = 0;
      Instr = ins;
      for (int g = 0; g < 64 && expQ.size() > 0 && expQ[0].busy; g++) begin
         @(posedge Clk); #1;
      end
      if (expQ.size() > 0 && expQ[0].busy) begin
         checks++; errors++;
         $display("FAIL issue_wait: controller still busy, required idle at %0t", $time);
      end
      model(ins, ack);
      if (expQ.size() == 0) expQ.push_back(mk(0, 0, 2'd0, 0, 0, 0, 0, ins));
      nBusy = 0;
      foreach (tr[i]) begin
         expQ.push_back(tr[i]);
         if (tr[i].busy) nBusy++;
      end
      InstrValid = 1'b1;
      for (int k = 1; k <= nBusy; k++) begin
         @(posedge Clk); #1;
         if (k == 1) begin
            if (nextIns < 0) begin
               InstrValid = 1'b0;
               Instr = ~ins;
            end else begin
               Instr = nextIns[15:0];
            end
         end
         MemAck = ((op == 8 || op == 9) && ack >= 1 && k == 1 + ack) ||
                  (op >= 1 && op <= 7 && ack > 0 && k <= 2);
         mc += int'(MemReq);
         if (k == rstAt) begin
            #2 Rst = 1'b0;
            #1 chk("async_rst_outs",
                   32'({InstrReady, SelA, SelB, SelWR, WE, Cen, DataSel, Imm, AluOp,
                        MemReq, MemWr, Busy, Illegal, Timeout}), 32'd0);
            expQ.delete();
            MemAck = 1'b0;
            @(posedge Clk); #1 Rst = 1'b1;
            return;
         end
      end
      @(posedge Clk); #1 MemAck = 1'b0;
   endtask

   always @(negedge Clk) begin
      rec_t e;
      if (!Rst) begin
         chk("rst_outs",
             32'({InstrReady, SelA, SelB, SelWR, WE, Cen, DataSel, Imm, AluOp,
                  MemReq, MemWr, Busy, Illegal, Timeout}), 32'd0);
      end else begin
         if (expQ.size() > 0) e = expQ.pop_front();
         else                 e = mk(0, 0, 2'd0, 0, 0, 0, 0, 16'h0000);
         chk("InstrReady", 32'(InstrReady), 32'(!e.busy));
         chk("Busy",       32'(Busy),       32'(e.busy));
         chk("Cen",        32'(Cen),        32'(e.busy));
         chk("WE",         32'(WE),         32'(e.we));
         chk("MemReq",     32'(MemReq),     32'(e.mreq));
         chk("MemWr",      32'(MemWr),      32'(e.mwr));
         chk("Illegal",    32'(Illegal),    32'(e.ill));
         chk("Timeout",    32'(Timeout),    32'(e.tmo));
         if (e.busy) begin
            chk("SelA",  32'(SelA),  32'(e.sa));
            chk("SelB",  32'(SelB),  32'(e.sb));
            chk("SelWR", 32'(SelWR), 32'(e.sw));
            chk("Imm",   32'(Imm),   32'(e.imm));
            chk("AluOp", 32'(AluOp), 32'(e.alu));
         end
         if (e.we) chk("DataSel", 32'(DataSel), 32'(e.ds));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Hand-computed anchors for the trace model.
      model(16'h1650, 0);
      chk("pin_add_len", 32'(tr.size()), 32'd2);
      chk("pin_add_dec", 32'({tr[0].sa, tr[0].sb}), 32'({3'd1, 3'd2}));
      chk("pin_add_wb",  32'({tr[1].we, tr[1].sw, tr[1].ds, tr[1].alu}),
                         32'({1'b1, 3'd3, 2'd0, 3'd1}));
      model(16'h7AA7, 0);
      chk("pin_ldi_wb",  32'({tr[1].we, tr[1].sw, tr[1].ds, tr[1].imm}),
                         32'({1'b1, 3'd5, 2'd1, 8'hA7}));
      model(16'h8500, 3);
      chk("pin_ld_len",  32'(tr.size()), 32'd5);
      chk("pin_ld_wb",   32'({tr[4].we, tr[4].sw, tr[4].ds, tr[3].mreq, tr[3].mwr}),
                         32'({1'b1, 3'd2, 2'd2, 1'b1, 1'b0}));
      model(16'h9070, 0);
      chk("pin_st_len",  32'(tr.size()), 32'd17);
      chk("pin_st_tmo",  32'({tr[16].tmo, tr[16].we, tr[16].busy, tr[15].mwr}),
                         32'({1'b1, 1'b0, 1'b0, 1'b1}));

      repeat (3) @(posedge Clk);
      #1 Rst = 1'b1;

      issue(16'h1650, 0, -1, 0, memCnt);             // ADD r3,r1,r2
      issue(16'h2A58, 0, -1, 0, memCnt);             // SUB back-to-back
      issue(16'h7AA7, 0, -1, 0, memCnt);             // LDI r5,0xA7
      issue(16'h8500, 3, -1, 0, memCnt);             // LD r2,[r4], ack on 3rd cycle
      chk("ld_memreq_cycles", 32'(memCnt), 32'd3);
      issue(16'h9070, 0, -1, 0, memCnt);             // ST never acknowledged
      chk("st_memreq_cycles", 32'(memCnt), 32'd15);
      issue(16'h9070, 2, -1, 0, memCnt);             // ST acknowledged
      chk("st_ack_cycles", 32'(memCnt), 32'd2);
      issue(16'h8500, TO, -1, 0, memCnt);            // ack coincides with timeout
      issue(16'h0000, 0, -1, 0, memCnt);             // NOP
      issue(16'hC000, 0, 16'h3E28, 0, memCnt);       // illegal, valid held high
      issue(16'h3E28, 0, -1, 0, memCnt);             // AND accepted on return to IDLE
      issue(16'h6180, 1, -1, 0, memCnt);             // MOV with stray MemAck
      issue(16'h5123, 0, -1, 0, memCnt);             // XOR
      issue(16'h8500, 0, -1, 3, memCnt);             // reset mid-MEM
      issue(16'h1650, 0, -1, 0, memCnt);             // ADD after reset

      repeat (4) @(posedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_seq_ctrl.md
REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max cycles waiting for MemAck before abort (1..255).
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 InstrValid  in  1  instruction offered.
REQ-005 Instr  in  16  instruction: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [7:0] imm (LDI only).
REQ-006 InstrReady  out  1  controller accepts instruction this cycle.
REQ-007 SelA, SelB, SelWR  out  3 each  register-file read/write selects.
REQ-008 WE  out  1  register-file write enable.
REQ-009 Cen  out  1  register-file clock enable.
REQ-010 DataSel  out  2  write-data mux: 0=ALU, 1=immediate, 2=memory.
REQ-011 Imm  out  8  immediate for LDI.
REQ-012 AluOp  out  3  ALU function, op[2:0].
REQ-013 MemReq, MemWr  out  1 each  memory request / write qualifier.
REQ-014 MemAck  in  1  memory completion.
REQ-015 Busy  out  1  high whenever state is not IDLE.
REQ-016 Illegal, Timeout  out  1 each  single-cycle error pulses.

Function
REQ-017 States SHALL be IDLE, DECODE, MEM, WB.
REQ-018 InstrReady SHALL equal (state==IDLE) AND Rst high; handshake completes on InstrValid & InstrReady at a rising edge.
REQ-019 On handshake, Instr SHALL be latched and state SHALL go IDLE->DECODE; Instr changes afterwards are ignored until the next handshake.
REQ-020 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV (rd<=ra), 7 LDI, 8 LD (rd<=mem[ra]), 9 ST (mem[ra]<=rb), 10-15 illegal.
REQ-021 From DECODE through WB/MEM, SelA=ra, SelB=rb, SelWR=rd, Imm=imm, AluOp=op[2:0] SHALL be held stable; Cen SHALL be 1 in DECODE, MEM, WB and 0 in IDLE.
REQ-022 DECODE transitions: ops 1-7 -> WB; 8, 9 -> MEM; 0 -> IDLE; 10-15 -> IDLE with Illegal=1 for exactly one cycle.
REQ-023 In MEM, MemReq=1 SHALL be held and MemWr=1 for ST, 0 for LD, until MemAck sampled high or timeout.
REQ-024 MemAck high in MEM: LD -> WB; ST -> IDLE; MemReq SHALL deassert the following cycle.
REQ-025 A wait counter SHALL clear on MEM entry and increment each MEM cycle without MemAck; at MEM_TIMEOUT cycles, state -> IDLE, Timeout=1 for one cycle, no register write.
REQ-026 MemAck and timeout in the same cycle: MemAck SHALL win.
REQ-027 WB SHALL last exactly one cycle with WE=1 and DataSel=0 for ops 1-6, 1 for LDI, 2 for LD, then -> IDLE.
REQ-028 WE SHALL be 0 in every state except WB; MemAck outside MEM SHALL be ignored.
REQ-029 Latency from handshake edge: ALU/LDI WE high 2 cycles later; NOP/illegal back to IDLE 2 cycles later; next instruction accepted 3 cycles after an ALU handshake.

Reset
REQ-030 Rst low SHALL immediately force state IDLE and all outputs 0 (InstrReady, SelA/B/WR, WE, Cen, DataSel, Imm, AluOp, MemReq, MemWr, Busy, Illegal, Timeout), independent of Clk.
REQ-031 Reset during MEM or WB SHALL abort the operation with no WE pulse after release; InstrReady SHALL be 1 on the first edge after Rst returns high.

Verification
REQ-032 ADD r3,r1,r2 (0x1650) -> DECODE SelA=1 SelB=2; next cycle WE=1 SelWR=3 DataSel=0 AluOp=1; IDLE after.
REQ-033 LDI r5,0xA7 (0x7AA7) -> WB with WE=1 SelWR=5 DataSel=1 Imm=0xA7.
REQ-034 LD r2,[r4] (0x8500), MemAck after 3 cycles -> MemReq=1 MemWr=0 for 3 cycles, then WE=1 SelWR=2 DataSel=2.
REQ-035 ST [r1],r6 (0x9070) with MemAck never asserted -> MemReq high 15 cycles, Timeout pulse, no WE, InstrReady=1 next cycle.
REQ-036 Opcode 0xC with InstrValid held high -> one Illegal pulse, no WE, following instruction accepted on return to IDLE.
REQ-037 Rst low mid-MEM of LD -> all outputs 0 asynchronously; no WE after release; new ADD completes normally.
